uart_rx_fifo: RTL and testbench

//  Parametrised UART receive channel: oversampled serial deframer feeding a show-ahead FIFO.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_deframer.sv | 107 ++++++++++
 rtl/uart_rx_fifo.sv | 113 +++++++++++
 tb/tb_uart_rx_fifo.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive channel.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PAR,
    RX_STOP
  } rx_state_e;

  localparam int MIN_BAUD = 4;

  // Expected parity bit for zero-extended data; odd=1 selects odd parity.
  function automatic logic par_calc(input logic [15:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_deframer.sv
// Oversampled UART deframer: input synchroniser, start/data/parity/stop FSM,
// one-clock result pulses per completed frame.
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [15:0]       i_baud,
  input  logic              i_par_en,
  input  logic              i_par_odd,
  input  logic              i_rx,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_frame_err,
  output logic              o_par_err,
  output logic              o_busy
);

  rx_state_e         r_state, w_next;
  logic              r_rx_s1, r_rx_s2, r_rx_prev;
  logic [15:0]       r_baud, r_cnt;
  logic [3:0]        r_bit_idx;
  logic [DATA_W-1:0] r_shift;
  logic              r_par_en, r_par_odd, r_par_bad;
  logic              r_valid, r_frame_err, r_par_err;
  logic              w_fall, w_tick, w_emit, w_ferr, w_perr;
  logic [15:0]       w_baud_eff;

  assign w_fall     = r_rx_prev & ~r_rx_s2;
  assign w_tick     = (r_cnt == 16'd0);
  assign w_baud_eff = (i_baud < 16'(MIN_BAUD)) ? 16'(MIN_BAUD) : i_baud;

  // Synchroniser flops reset high so a reset never fakes a start edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_s1     <= 1'b1;
      r_rx_s2     <= 1'b1;
      r_rx_prev   <= 1'b1;
      r_state     <= RX_IDLE;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_par_err   <= 1'b0;
    end else begin
      r_rx_s1     <= i_rx;
      r_rx_s2     <= r_rx_s1;
      r_rx_prev   <= r_rx_s2;
      r_state     <= w_next;
      r_valid     <= w_emit;
      r_frame_err <= w_ferr;
      r_par_err   <= w_perr;
    end
  end

  always_comb begin
    w_next = r_state;
    w_emit = 1'b0;
    w_ferr = 1'b0;
    w_perr = 1'b0;
    case (r_state)
      RX_IDLE:  if (w_fall) w_next = RX_START;
      RX_START: if (w_tick) w_next = r_rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_tick && r_bit_idx == 4'(DATA_W - 1))
                  w_next = r_par_en ? RX_PAR : RX_STOP;
      RX_PAR:   if (w_tick) w_next = RX_STOP;
      RX_STOP: begin
        if (w_tick) begin
          w_next = RX_IDLE;
          w_ferr = ~r_rx_s2;
          w_perr = r_par_bad;
          w_emit = r_rx_s2 & ~r_par_bad;
        end
      end
      default:  w_next = RX_IDLE;
    endcase
  end

  // Bit timing: half a bit to the start-bit centre, then a full bit per sample.
  always_ff @(posedge i_clk) begin
    if (r_state == RX_IDLE) begin
      if (w_fall) begin
        r_baud    <= w_baud_eff;
        r_cnt     <= (w_baud_eff >> 1) - 16'd1;
        r_par_en  <= i_par_en;
        r_par_odd <= i_par_odd;
        r_bit_idx <= 4'd0;
        r_par_bad <= 1'b0;
      end
    end else begin
      r_cnt <= w_tick ? (r_baud - 16'd1) : (r_cnt - 16'd1);
      if (w_tick && r_state == RX_DATA) begin
        r_shift   <= {r_rx_s2, r_shift[DATA_W-1:1]};
        r_bit_idx <= r_bit_idx + 4'd1;
      end
      if (w_tick && r_state == RX_PAR)
        r_par_bad <= (r_rx_s2 != par_calc(16'(r_shift), r_par_odd));
    end
  end

  assign o_data      = r_shift;
  assign o_valid     = r_valid;
  assign o_frame_err = r_frame_err;
  assign o_par_err   = r_par_err;
  assign o_busy      = (r_state != RX_IDLE);

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive channel top: deframer feeding a show-ahead FIFO, sticky error
// flags and a line-activity indicator with idle timeout.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 3,
  parameter int IDLE_CYC   = 46080000,
  parameter int CNT_W      = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [15:0]         i_baud,
  input  logic                i_par_en,
  input  logic                i_par_odd,
  input  logic                i_rx,
  input  logic                i_read,
  input  logic                i_clr_err,
  output logic                o_ready,
  output logic [DATA_W-1:0]   o_data,
  output logic [DEPTH_LOG2:0] o_count,
  output logic                o_overflow,
  output logic                o_frame_err,
  output logic                o_par_err,
  output logic                o_used
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [DATA_W-1:0]     r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overflow, r_frame_err, r_par_err, r_used;
  logic [CNT_W-1:0]      r_idle_cnt;

  logic [DATA_W-1:0]     w_rx_data;
  logic                  w_rx_valid, w_rx_ferr, w_rx_perr, w_busy;
  logic                  w_full, w_pop, w_push, w_ovf;

  uart_rx_deframer #(.DATA_W(DATA_W)) u_deframer (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_baud      (i_baud),
    .i_par_en    (i_par_en),
    .i_par_odd   (i_par_odd),
    .i_rx        (i_rx),
    .o_data      (w_rx_data),
    .o_valid     (w_rx_valid),
    .o_frame_err (w_rx_ferr),
    .o_par_err   (w_rx_perr),
    .o_busy      (w_busy)
  );

  // A pop frees the slot the same cycle, so a full FIFO still accepts a push then.
  assign w_full = (r_count == FULL_CNT);
  assign w_pop  = i_read && (r_count != '0);
  assign w_push = w_rx_valid && (!w_full || w_pop);
  assign w_ovf  = w_rx_valid && w_full && !w_pop;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_rx_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
      r_par_err   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_overflow  <= w_ovf     | (r_overflow  & ~i_clr_err);
      r_frame_err <= w_rx_ferr | (r_frame_err & ~i_clr_err);
      r_par_err   <= w_rx_perr | (r_par_err   & ~i_clr_err);
    end
  end

  // Idle timer runs only after activity; it parks at zero once o_used drops.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_used     <= 1'b0;
      r_idle_cnt <= '0;
    end else if (w_busy) begin
      r_used     <= 1'b1;
      r_idle_cnt <= '0;
    end else if (r_used) begin
      if (r_idle_cnt == CNT_W'(IDLE_CYC - 1)) begin
        r_used     <= 1'b0;
        r_idle_cnt <= '0;
      end else begin
        r_idle_cnt <= r_idle_cnt + 1'b1;
      end
    end
  end

  assign o_ready     = (r_count != '0);
  assign o_data      = o_ready ? r_mem[r_rd_ptr] : '0;
  assign o_count     = r_count;
  assign o_overflow  = r_overflow;
  assign o_frame_err = r_frame_err;
  assign o_par_err   = r_par_err;
  assign o_used      = r_used;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed vector table, hand-written
// corner sequences, and randomized frames against a queue-based model.
module tb_uart_rx_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] i_baud = 16'd16;
  logic        i_par_en = 1'b0, i_par_odd = 1'b0, i_rx = 1'b1;
  logic        i_read = 1'b0, i_clr_err = 1'b0;
  logic        o_ready, o_overflow, o_frame_err, o_par_err, o_used;
  logic [7:0]  o_data;
  logic [3:0]  o_count;

  uart_rx_fifo #(.DATA_W(8), .DEPTH_LOG2(3), .IDLE_CYC(100), .CNT_W(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_baud(i_baud), .i_par_en(i_par_en),
    .i_par_odd(i_par_odd), .i_rx(i_rx), .i_read(i_read), .i_clr_err(i_clr_err),
    .o_ready(o_ready), .o_data(o_data), .o_count(o_count),
    .o_overflow(o_overflow), .o_frame_err(o_frame_err), .o_par_err(o_par_err),
    .o_used(o_used)
  );

  always #5 clk = ~clk;

  int pcnt = 0;
  always @(posedge clk) pcnt <= pcnt + 1;

  int n_chk = 0, n_err = 0;
  int frame_p0 = 0;

  typedef struct {
    logic [7:0] d;
    int         baud;
    logic       pe, podd, bad_par, stop, clr_after;
    int         exp_count;
    logic [7:0] exp_head;
    logic       exp_ovf, exp_ferr, exp_perr;
  } vec_t;

  vec_t vecs[6];
  logic [7:0] q[$];
  logic m_ovf, m_ferr, m_perr;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Line bit k is driven for b consecutive negedges; t=0 is the start-bit fall.
  task automatic send_frame(input logic [7:0] d, input int b, input logic pe,
                            input logic podd, input logic bad_par, input logic stop,
                            input int read_at);
    logic fr[11];
    int   n;
    for (int i = 0; i < 11; i++) fr[i] = 1'b1;
    fr[0] = 1'b0;
    for (int i = 0; i < 8; i++) fr[1+i] = d[i];
    n = 9;
    if (pe) begin
      fr[n] = (^d) ^ podd ^ bad_par;
      n++;
    end
    fr[n] = stop;
    n++;
    @(negedge clk);
    frame_p0  = pcnt;
    i_baud    = 16'(b);
    i_par_en  = pe;
    i_par_odd = podd;
    for (int t = 0; t < n * b; t++) begin
      if (t > 0) @(negedge clk);
      i_rx   = fr[t / b];
      i_read = (t == read_at);
    end
    @(negedge clk);
    i_rx   = 1'b1;
    i_read = 1'b0;
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  task automatic read_head(input string nm, input logic [7:0] exp);
    @(negedge clk);
    check({nm, " ready"}, o_ready, 1);
    check(nm, o_data, exp);
    i_read = 1'b1;
    @(negedge clk);
    i_read = 1'b0;
  endtask

  task automatic clear_err();
    @(negedge clk);
    i_clr_err = 1'b1;
    @(negedge clk);
    i_clr_err = 1'b0;
  endtask

  task automatic check_flags(input string nm, input logic ovf, input logic fe, input logic pe);
    check({nm, " overflow"}, o_overflow, ovf);
    check({nm, " frame_err"}, o_frame_err, fe);
    check({nm, " par_err"}, o_par_err, pe);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 16, 0, 0, 0, 1, 0, 1, 8'hA5, 0, 0, 0};
    vecs[1] = '{8'h3C,  8, 1, 0, 0, 1, 0, 2, 8'hA5, 0, 0, 0};
    vecs[2] = '{8'h03, 16, 1, 0, 1, 1, 0, 2, 8'hA5, 0, 0, 1};
    vecs[3] = '{8'h55, 16, 0, 0, 0, 0, 1, 2, 8'hA5, 0, 1, 1};
    vecs[4] = '{8'h7E,  5, 1, 1, 0, 1, 0, 3, 8'hA5, 0, 0, 0};
    vecs[5] = '{8'h81,  4, 0, 0, 0, 1, 0, 4, 8'hA5, 0, 0, 0};

    repeat (3) @(negedge clk);
    check("rst ready", o_ready, 0);
    check("rst count", o_count, 0);
    check("rst data", o_data, 0);
    check("rst used", o_used, 0);
    check_flags("rst", 0, 0, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].d, vecs[v].baud, vecs[v].pe, vecs[v].podd,
                 vecs[v].bad_par, vecs[v].stop, -1);
      settle();
      check($sformatf("vec%0d count", v), o_count, vecs[v].exp_count);
      check($sformatf("vec%0d head", v), o_data, vecs[v].exp_head);
      check_flags($sformatf("vec%0d", v), vecs[v].exp_ovf, vecs[v].exp_ferr, vecs[v].exp_perr);
      if (vecs[v].clr_after) begin
        clear_err();
        check_flags($sformatf("vec%0d clr", v), 0, 0, 0);
      end
    end
    read_head("tbl rd0", 8'hA5);
    read_head("tbl rd1", 8'h3C);
    read_head("tbl rd2", 8'h7E);
    read_head("tbl rd3", 8'h81);
    @(negedge clk);
    check("tbl empty ready", o_ready, 0);
    i_read = 1'b1;
    @(negedge clk);
    i_read = 1'b0;
    @(negedge clk);
    check("empty read count", o_count, 0);

    // Nine frames into an eight-deep FIFO with no reads.
    for (int i = 0; i < 9; i++) send_frame(8'(i), 4, 0, 0, 0, 1, -1);
    settle();
    check("ovf count", o_count, 8);
    check("ovf flag", o_overflow, 1);
    for (int i = 0; i < 8; i++) read_head($sformatf("ovf rd%0d", i), 8'(i));
    @(negedge clk);
    check("ovf drained", o_count, 0);
    clear_err();
    check("ovf cleared", o_overflow, 0);

    // Full FIFO; the read lands on the push clock: 3 + B/2 + 9*B after the fall.
    for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 4, 0, 0, 0, 1, -1);
    settle();
    check("coin pre count", o_count, 8);
    send_frame(8'h18, 16, 0, 0, 0, 1, 3 + 8 + 9 * 16);
    settle();
    check("coin count", o_count, 8);
    check("coin overflow", o_overflow, 0);
    for (int i = 0; i < 8; i++) read_head($sformatf("coin rd%0d", i), 8'h11 + 8'(i));

    // Return to idle is at the stop sample, 2 + B/2 + 9*B clocks after the fall.
    send_frame(8'h5A, 16, 0, 0, 0, 1, -1);
    while (pcnt < frame_p0 + 1 + 154 + 99) @(negedge clk);
    check("used before timeout", o_used, 1);
    @(negedge clk);
    check("used after timeout", o_used, 0);
    check("idle count", o_count, 1);

    @(negedge clk);
    i_rx = 1'b0;
    repeat (2) @(negedge clk);
    i_rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch used", o_used, 1);
    check("glitch count", o_count, 1);
    check_flags("glitch", 0, 0, 0);
    read_head("glitch head", 8'h5A);

    // Reset while a 0xFF frame is on the line: nothing may be pushed.
    @(negedge clk);
    i_baud = 16'd16;
    i_par_en = 1'b0;
    i_rx = 1'b0;
    repeat (16) @(negedge clk);
    i_rx = 1'b1;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    check("midrst count", o_count, 0);
    check_flags("midrst", 0, 0, 0);

    q.delete();
    m_ovf = 0; m_ferr = 0; m_perr = 0;
    for (int f = 0; f < 40; f++) begin
      logic [7:0] d;
      int b, nr;
      logic pe, podd, bp, st;
      d    = 8'($urandom);
      b    = $urandom_range(4, 12);
      pe   = 1'($urandom_range(0, 1));
      podd = 1'($urandom_range(0, 1));
      bp   = pe && ($urandom_range(0, 7) == 0);
      st   = ($urandom_range(0, 7) != 0);
      send_frame(d, b, pe, podd, bp, st, -1);
      settle();
      if (!st) m_ferr = 1;
      if (bp) m_perr = 1;
      if (st && !bp) begin
        if (q.size() == 8) m_ovf = 1;
        else q.push_back(d);
      end
      check($sformatf("rnd%0d count", f), o_count, q.size());
      check($sformatf("rnd%0d ready", f), o_ready, (q.size() != 0));
      check_flags($sformatf("rnd%0d", f), m_ovf, m_ferr, m_perr);
      nr = (f < 12) ? 0 : (($urandom_range(0, 4) == 0) ? 3 : $urandom_range(0, 1));
      for (int r = 0; r < nr; r++) begin
        if (q.size() > 0) begin
          read_head($sformatf("rnd%0d rd%0d", f, r), q[0]);
          void'(q.pop_front());
        end else begin
          @(negedge clk);
          i_read = 1'b1;
          @(negedge clk);
          i_read = 1'b0;
          check($sformatf("rnd%0d empty rd", f), o_count, 0);
        end
      end
      if ($urandom_range(0, 5) == 0) begin
        clear_err();
        m_ovf = 0; m_ferr = 0; m_perr = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
